// File: rtl/aes_tiled_round_seq.sv
// aes_tiled_round_seq
// Sequences one AES round over a shared tiled AES datapath. A request
// carries a 128-bit state and round key. The sequencer issues four
// SubBytes/ShiftRows ops, optionally four MixColumns ops, applies
// AddRoundKey locally and returns the new state.
//
// Ports:
//   g_clk, g_reset        clock, synchronous active-high reset
//   req_*                 request channel (valid/ready, dec, final, state, key)
//   rsp_*                 response channel (valid/ready, state, err)
//   dp_*                  command/result channel of the tiled AES unit
//
// Watchdog: WAIT_W-bit counter of consecutive stalled datapath cycles.
// After 2^WAIT_W-1 stalled cycles the op is abandoned and an error
// response is returned.
module aes_tiled_round_seq #(
    parameter int WAIT_W = 8
) (
    input  logic         g_clk,
    input  logic         g_reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_dec,
    input  logic         req_final,
    input  logic [127:0] req_state,
    input  logic [127:0] req_key,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_state,
    output logic         rsp_err,
    output logic         dp_valid,
    output logic         dp_dec,
    output logic         dp_op_sb,
    output logic         dp_op_sbsr,
    output logic         dp_op_mix,
    output logic         dp_hi,
    output logic [31:0]  dp_rs1,
    output logic [31:0]  dp_rs2,
    input  logic         dp_ready,
    input  logic [31:0]  dp_rd
);

    typedef enum logic [2:0] {IDLE, SBSR, ARK, MIX, RSP} state_e;

    localparam logic [WAIT_W-1:0] WdLast = {{(WAIT_W-1){1'b1}}, 1'b0};
    localparam logic [WAIT_W-1:0] WdOne  = {{(WAIT_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [1:0]         step_q, step_d;
    // sw holds the request state S during SBSR and is reused for the
    // MixColumns results U, since S is dead once SBSR completes.
    logic [3:0][31:0]   sw_q, sw_d;
    logic [3:0][31:0]   tw_q, tw_d;
    logic [127:0]       key_q, key_d;
    logic               dec_q, dec_d;
    logic               fin_q, fin_d;
    logic               useU_q, useU_d;
    logic [WAIT_W-1:0]  wdog_q, wdog_d;
    logic               reqReady_q, reqReady_d;
    logic               rspValid_q, rspValid_d;
    logic               rspErr_q, rspErr_d;
    logic [127:0]       rspState_q, rspState_d;
    logic               dpValid_q, dpValid_d;
    logic               dpDec_q, dpDec_d;
    logic               dpSbsr_q, dpSbsr_d;
    logic               dpMix_q, dpMix_d;
    logic               dpHi_q, dpHi_d;
    logic [31:0]        dpRs1_q, dpRs1_d;
    logic [31:0]        dpRs2_q, dpRs2_d;

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        sw_d       = sw_q;
        tw_d       = tw_q;
        key_d      = key_q;
        dec_d      = dec_q;
        fin_d      = fin_q;
        useU_d     = useU_q;
        wdog_d     = wdog_q;
        rspErr_d   = rspErr_q;
        rspState_d = rspState_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    sw_d    = req_state;
                    key_d   = req_key;
                    dec_d   = req_dec;
                    fin_d   = req_final;
                    step_d  = 2'd0;
                    useU_d  = 1'b0;
                    wdog_d  = '0;
                    state_d = SBSR;
                end
            end
            SBSR, MIX: begin
                if (dp_ready) begin
                    wdog_d = '0;
                    if (state_q == SBSR) begin
                        tw_d[step_q] = dp_rd;
                    end else begin
                        sw_d[step_q] = dp_rd;
                    end
                    step_d = step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        if (state_q == SBSR) begin
                            // Decrypt and final rounds add the key straight after SBSR.
                            state_d = (dec_q || fin_q) ? ARK : MIX;
                        end else begin
                            useU_d  = 1'b1;
                            state_d = dec_q ? RSP : ARK;
                        end
                    end
                end else if (wdog_q == WdLast) begin
                    wdog_d   = '0;
                    rspErr_d = 1'b1;
                    state_d  = RSP;
                end else begin
                    wdog_d = wdog_q + WdOne;
                end
            end
            ARK: begin
                if (useU_q) begin
                    sw_d = sw_q ^ key_q;
                end else begin
                    tw_d = tw_q ^ key_q;
                end
                step_d  = 2'd0;
                state_d = (dec_q && !fin_q) ? MIX : RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    rspErr_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Result is frozen on entry to RSP so it stays stable under backpressure.
        if (state_d == RSP && state_q != RSP) begin
            rspState_d = useU_d ? sw_d : tw_d;
        end

        reqReady_d = (state_d == IDLE);
        rspValid_d = (state_d == RSP);

        // Datapath command is computed from next state so it is registered
        // and lands in the same cycle the FSM enters the step.
        dpValid_d = (state_d == SBSR) || (state_d == MIX);
        dpSbsr_d  = (state_d == SBSR);
        dpMix_d   = (state_d == MIX);
        dpDec_d   = dpValid_d ? dec_d : 1'b0;
        dpHi_d    = 1'b0;
        dpRs1_d   = '0;
        dpRs2_d   = '0;
        if (state_d == SBSR) begin
            dpHi_d  = step_d[0];
            dpRs1_d = sw_d[{1'b0, step_d[1]}];
            dpRs2_d = sw_d[{1'b1, step_d[1]}];
        end else if (state_d == MIX) begin
            // Pairs by step: (T0,T2) (T2,T0) (T1,T3) (T3,T1).
            dpRs1_d = tw_d[{step_d[0], step_d[1]}];
            dpRs2_d = tw_d[{~step_d[0], step_d[1]}];
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q    <= IDLE;
            step_q     <= 2'd0;
            sw_q       <= '0;
            tw_q       <= '0;
            key_q      <= '0;
            dec_q      <= 1'b0;
            fin_q      <= 1'b0;
            useU_q     <= 1'b0;
            wdog_q     <= '0;
            reqReady_q <= 1'b1;
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspState_q <= '0;
            dpValid_q  <= 1'b0;
            dpDec_q    <= 1'b0;
            dpSbsr_q   <= 1'b0;
            dpMix_q    <= 1'b0;
            dpHi_q     <= 1'b0;
            dpRs1_q    <= '0;
            dpRs2_q    <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            sw_q       <= sw_d;
            tw_q       <= tw_d;
            key_q      <= key_d;
            dec_q      <= dec_d;
            fin_q      <= fin_d;
            useU_q     <= useU_d;
            wdog_q     <= wdog_d;
            reqReady_q <= reqReady_d;
            rspValid_q <= rspValid_d;
            rspErr_q   <= rspErr_d;
            rspState_q <= rspState_d;
            dpValid_q  <= dpValid_d;
            dpDec_q    <= dpDec_d;
            dpSbsr_q   <= dpSbsr_d;
            dpMix_q    <= dpMix_d;
            dpHi_q     <= dpHi_d;
            dpRs1_q    <= dpRs1_d;
            dpRs2_q    <= dpRs2_d;
        end
    end

    assign req_ready  = reqReady_q;
    assign rsp_valid  = rspValid_q;
    assign rsp_err    = rspErr_q;
    assign rsp_state  = rspState_q;
    assign dp_valid   = dpValid_q;
    assign dp_dec     = dpDec_q;
    assign dp_op_sb   = 1'b0;
    assign dp_op_sbsr = dpSbsr_q;
    assign dp_op_mix  = dpMix_q;
    assign dp_hi      = dpHi_q;
    assign dp_rs1     = dpRs1_q;
    assign dp_rs2     = dpRs2_q;

endmodule

// File: tb/tb_aes_tiled_round_seq.sv
// tb_aes_tiled_round_seq
// Bench for aes_tiled_round_seq. A behavioural tiled AES unit answers
// datapath commands; every request pushes its expected datapath command
// sequence and expected result onto queues that are popped as the DUT
// issues commands and returns responses.
module tb_aes_tiled_round_seq;

    localparam int WAIT_W = 4;

    logic         g_clk = 1'b0;
    logic         g_reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_dec = 1'b0;
    logic         req_final = 1'b0;
    logic [127:0] req_state = '0;
    logic [127:0] req_key = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_state;
    logic         rsp_err;
    logic         dp_valid, dp_dec, dp_op_sb, dp_op_sbsr, dp_op_mix, dp_hi;
    logic [31:0]  dp_rs1, dp_rs2;
    logic         dp_ready = 1'b0;
    logic [31:0]  dp_rd = '0;

    aes_tiled_round_seq #(.WAIT_W(WAIT_W)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_dec(req_dec),
        .req_final(req_final), .req_state(req_state), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_state(rsp_state),
        .rsp_err(rsp_err),
        .dp_valid(dp_valid), .dp_dec(dp_dec), .dp_op_sb(dp_op_sb),
        .dp_op_sbsr(dp_op_sbsr), .dp_op_mix(dp_op_mix), .dp_hi(dp_hi),
        .dp_rs1(dp_rs1), .dp_rs2(dp_rs2), .dp_ready(dp_ready), .dp_rd(dp_rd)
    );

    always #5 g_clk = ~g_clk;

    int cyc = 0;
    always @(posedge g_clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          mix;
        bit          hi;
        bit          dec;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } dpCmd_t;

    dpCmd_t       dpQ[$];
    logic [127:0] rspQ[$];
    logic [7:0]   sbox[256];
    logic [7:0]   isbox[256];

    bit respOn = 0;
    bit stuck = 0;
    int stallAt = -1;
    int stallLeft = 0;
    int opsDone = 0;
    int sbsrOps = 0;
    int mixOps = 0;
    int stalledSeen = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Stand-in for the tiled unit: substitutes one 16-bit half of each operand.
    function automatic logic [31:0] dpSbsr(input logic [31:0] a, input logic [31:0] b,
                                           input bit hi, input bit dec);
        logic [31:0] src;
        logic [31:0] r;
        src = hi ? {b[31:16], a[31:16]} : {b[15:0], a[15:0]};
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = dec ? isbox[src[8*i +: 8]] : sbox[src[8*i +: 8]];
        end
        return r;
    endfunction

    function automatic logic [31:0] dpMix(input logic [31:0] a, input logic [31:0] b, input bit dec);
        logic [7:0]  c0, c1, c2, c3;
        logic [31:0] r;
        c0 = dec ? 8'h0e : 8'h02;
        c1 = dec ? 8'h0b : 8'h03;
        c2 = dec ? 8'h0d : 8'h01;
        c3 = dec ? 8'h09 : 8'h01;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = gmul(c0, a[8*i +: 8]) ^ gmul(c1, a[8*((i+1)%4) +: 8])
                        ^ gmul(c2, b[8*((i+2)%4) +: 8]) ^ gmul(c3, b[8*((i+3)%4) +: 8]);
        end
        return r;
    endfunction

    task automatic buildTables;
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] xb;
        for (int x = 0; x < 256; x++) begin
            xb = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (xb != 8'h00 && gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x] = s;
            isbox[s] = xb;
        end
    endtask

    // Expected command schedule and result for one round request.
    task automatic modelRound(input bit dec, input bit fin, input logic [127:0] st,
                              input logic [127:0] key, output logic [127:0] res);
        logic [31:0] s[4], t[4], u[4], k[4], w[4];
        int          pa[4], pb[4];
        dpCmd_t      c;
        pa = '{0, 2, 1, 3};
        pb = '{2, 0, 3, 1};
        for (int i = 0; i < 4; i++) begin
            s[i] = st[32*i +: 32];
            k[i] = key[32*i +: 32];
        end
        for (int i = 0; i < 4; i++) begin
            c.mix = 0;
            c.hi  = (i % 2) == 1;
            c.dec = dec;
            c.rs1 = (i < 2) ? s[0] : s[1];
            c.rs2 = (i < 2) ? s[2] : s[3];
            t[i]  = dpSbsr(c.rs1, c.rs2, c.hi, dec);
            dpQ.push_back(c);
        end
        if (dec && !fin) begin
            for (int i = 0; i < 4; i++) t[i] = t[i] ^ k[i];
        end
        if (!fin) begin
            for (int i = 0; i < 4; i++) begin
                c.mix = 1;
                c.hi  = 0;
                c.dec = dec;
                c.rs1 = t[pa[i]];
                c.rs2 = t[pb[i]];
                u[i]  = dpMix(c.rs1, c.rs2, dec);
                dpQ.push_back(c);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (fin) w[i] = t[i] ^ k[i];
            else if (!dec) w[i] = u[i] ^ k[i];
            else w[i] = u[i];
        end
        res = {w[3], w[2], w[1], w[0]};
    endtask

    // Behavioural datapath: checks each presented command against the
    // expected schedule and answers it.
    initial begin
        forever begin
            @(negedge g_clk);
            if (respOn) begin
                if (dp_valid !== 1'b1) begin
                    dp_ready = 1'b0;
                    checks++;
                    if ({dp_op_sb, dp_op_sbsr, dp_op_mix} !== 3'b000) begin
                        failures++;
                        $display("[TB] FAIL dp_op_idle: ops=%b required 000", {dp_op_sb, dp_op_sbsr, dp_op_mix});
                    end
                end else begin
                    checks++;
                    if ({dp_op_sb, dp_op_sbsr, dp_op_mix} !== 3'b010 && {dp_op_sb, dp_op_sbsr, dp_op_mix} !== 3'b001) begin
                        failures++;
                        $display("[TB] FAIL dp_op_onehot: ops=%b required exactly one of sbsr/mix", {dp_op_sb, dp_op_sbsr, dp_op_mix});
                    end
                    checks++;
                    if (dpQ.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL dp_unexpected: command issued with none expected (rs1=%h rs2=%h)", dp_rs1, dp_rs2);
                    end else if ({dp_op_mix, dp_hi, dp_dec, dp_rs1, dp_rs2} !==
                                 {dpQ[0].mix, dpQ[0].hi, dpQ[0].dec, dpQ[0].rs1, dpQ[0].rs2}) begin
                        failures++;
                        $display("[TB] FAIL dp_cmd: got mix=%b hi=%b dec=%b rs1=%h rs2=%h required mix=%b hi=%b dec=%b rs1=%h rs2=%h",
                                 dp_op_mix, dp_hi, dp_dec, dp_rs1, dp_rs2,
                                 dpQ[0].mix, dpQ[0].hi, dpQ[0].dec, dpQ[0].rs1, dpQ[0].rs2);
                    end
                    if (stuck || (opsDone == stallAt && stallLeft > 0)) begin
                        dp_ready = 1'b0;
                        if (!stuck) stallLeft--;
                        stalledSeen++;
                    end else begin
                        dp_ready = 1'b1;
                        dp_rd = dp_op_mix ? dpMix(dp_rs1, dp_rs2, dp_dec) : dpSbsr(dp_rs1, dp_rs2, dp_hi, dp_dec);
                        if (dpQ.size() > 0) void'(dpQ.pop_front());
                        opsDone++;
                        if (dp_op_mix) mixOps++;
                        else sbsrOps++;
                    end
                end
            end
        end
    end

    task automatic doRequest(input bit dec, input bit fin, input logic [127:0] st,
                             input logic [127:0] key, output int hsCyc);
        logic [127:0] exp;
        modelRound(dec, fin, st, key, exp);
        rspQ.push_back(exp);
        for (int n = 0; n < 50 && req_ready !== 1'b1; n++) @(negedge g_clk);
        req_valid = 1'b1;
        req_dec   = dec;
        req_final = fin;
        req_state = st;
        req_key   = key;
        @(posedge g_clk);
        #1 hsCyc = cyc;
        @(negedge g_clk);
        req_valid = 1'b0;
    endtask

    task automatic waitRsp(input int hsCyc, input int limit, output bit got, output int lat);
        got = 0;
        for (int n = 0; n < limit; n++) begin
            if (rsp_valid === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge g_clk);
        end
        lat = cyc - hsCyc + 1;
    endtask

    task automatic ackRsp(output int ackCyc);
        rsp_ready = 1'b1;
        @(posedge g_clk);
        #1 ackCyc = cyc;
        @(negedge g_clk);
        rsp_ready = 1'b0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic test_reset;
        g_reset = 1'b1;
        repeat (3) @(negedge g_clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_err, dp_valid, dp_op_sb, dp_op_sbsr, dp_op_mix, dp_hi, dp_dec} !== 9'b100000000) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b required 100000000",
                     {req_ready, rsp_valid, rsp_err, dp_valid, dp_op_sb, dp_op_sbsr, dp_op_mix, dp_hi, dp_dec});
        end
        checks++;
        if (rsp_state !== 128'h0) begin
            failures++;
            $display("[TB] FAIL reset_rsp_state: got %h required 0", rsp_state);
        end
        checks++;
        if ({dp_rs1, dp_rs2} !== 64'h0) begin
            failures++;
            $display("[TB] FAIL reset_operands: got %h/%h required 0/0", dp_rs1, dp_rs2);
        end
        g_reset = 1'b0;
        @(negedge g_clk);
        respOn = 1;
    endtask

    // Runs one round and checks result, latency and op counts.
    task automatic test_round(input string name, input bit dec, input bit fin,
                              input logic [127:0] st, input logic [127:0] key,
                              input logic [127:0] literal, input bit useLiteral, input int reqLat);
        int hs, lat, ack, s0, m0;
        bit got;
        logic [127:0] exp;
        s0 = sbsrOps;
        m0 = mixOps;
        doRequest(dec, fin, st, key, hs);
        waitRsp(hs, 40, got, lat);
        exp = rspQ.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("[TB] FAIL %s_timeout: no rsp_valid within 40 cycles", name);
        end
        checks++;
        if (lat != reqLat) begin
            failures++;
            $display("[TB] FAIL %s_latency: got %0d required %0d", name, lat, reqLat);
        end
        checks++;
        if (rsp_state !== exp || rsp_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_result: got %h err=%b required %h err=0", name, rsp_state, rsp_err, exp);
        end
        if (useLiteral) begin
            checks++;
            if (rsp_state !== literal) begin
                failures++;
                $display("[TB] FAIL %s_literal: got %h required %h", name, rsp_state, literal);
            end
        end
        checks++;
        if (sbsrOps - s0 != 4 || mixOps - m0 != (fin ? 0 : 4)) begin
            failures++;
            $display("[TB] FAIL %s_opcount: got sbsr=%0d mix=%0d required 4/%0d", name, sbsrOps - s0, mixOps - m0, fin ? 0 : 4);
        end
        ackRsp(ack);
    endtask

    task automatic test_stall;
        int hs, lat, ack, st0;
        bit got;
        logic [127:0] exp;
        stallAt = opsDone + 2;
        stallLeft = 3;
        st0 = stalledSeen;
        doRequest(0, 0, rand128(), rand128(), hs);
        waitRsp(hs, 40, got, lat);
        exp = rspQ.pop_front();
        checks++;
        if (!got || lat != 13) begin
            failures++;
            $display("[TB] FAIL stall_latency: got %0d (seen=%0b) required 13", lat, got);
        end
        checks++;
        if (rsp_state !== exp) begin
            failures++;
            $display("[TB] FAIL stall_result: got %h required %h", rsp_state, exp);
        end
        checks++;
        if (stalledSeen - st0 != 3) begin
            failures++;
            $display("[TB] FAIL stall_cycles: got %0d required 3", stalledSeen - st0);
        end
        stallAt = -1;
        ackRsp(ack);
    endtask

    task automatic test_backpressure;
        int hs, lat, ack;
        bit got;
        logic [127:0] exp, held;
        doRequest(1, 0, rand128(), rand128(), hs);
        waitRsp(hs, 40, got, lat);
        exp = rspQ.pop_front();
        checks++;
        if (!got || lat != 10 || rsp_state !== exp) begin
            failures++;
            $display("[TB] FAIL bp_result: got %h lat=%0d required %h lat=10", rsp_state, lat, exp);
        end
        held = rsp_state;
        for (int i = 0; i < 5; i++) begin
            @(negedge g_clk);
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_state !== held) begin
                failures++;
                $display("[TB] FAIL bp_hold: got valid=%b ready=%b state=%h required 1/0/%h", rsp_valid, req_ready, rsp_state, held);
            end
        end
        ackRsp(ack);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_release: got valid=%b ready=%b required 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_watchdog;
        int hs, lat, ack, st0;
        bit got;
        logic [127:0] exp;
        st0 = stalledSeen;
        stuck = 1;
        doRequest(0, 0, rand128(), rand128(), hs);
        waitRsp(hs, 60, got, lat);
        exp = rspQ.pop_front();
        checks++;
        if (!got || lat != 16 || rsp_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wd_abort: got seen=%b lat=%0d err=%b required 1/16/1", got, lat, rsp_err);
        end
        checks++;
        if (stalledSeen - st0 != 15 || dp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wd_stalls: got %0d dp_valid=%b required 15/0", stalledSeen - st0, dp_valid);
        end
        dpQ.delete();
        stuck = 0;
        ackRsp(ack);
        checks++;
        if (rsp_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wd_err_clear: got %b required 0", rsp_err);
        end
        test_round("wd_next", 0, 0, rand128(), rand128(), '0, 0, 10);
    endtask

    task automatic test_reset_mid;
        int hs;
        bit sawRsp;
        doRequest(0, 0, rand128(), rand128(), hs);
        for (int n = 0; n < 20 && dp_op_mix !== 1'b1; n++) @(negedge g_clk);
        @(negedge g_clk);
        g_reset = 1'b1;
        @(negedge g_clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_err, dp_valid, dp_op_sbsr, dp_op_mix, dp_hi, dp_dec} !== 8'b10000000
            || {dp_rs1, dp_rs2} !== 64'h0 || rsp_state !== 128'h0) begin
            failures++;
            $display("[TB] FAIL midreset_values: got ctrl=%b rs1=%h rs2=%h state=%h required 10000000/0/0/0",
                     {req_ready, rsp_valid, rsp_err, dp_valid, dp_op_sbsr, dp_op_mix, dp_hi, dp_dec}, dp_rs1, dp_rs2, rsp_state);
        end
        g_reset = 1'b0;
        dpQ.delete();
        void'(rspQ.pop_back());
        sawRsp = 0;
        for (int i = 0; i < 15; i++) begin
            if (rsp_valid === 1'b1) sawRsp = 1;
            @(negedge g_clk);
        end
        checks++;
        if (sawRsp) begin
            failures++;
            $display("[TB] FAIL midreset_no_rsp: got a response required none");
        end
        test_round("post_reset", 1, 0, rand128(), rand128(), '0, 0, 10);
    endtask

    task automatic test_back_to_back;
        int hs, lat, ack;
        bit got;
        bit dec, fin;
        logic [127:0] exp;
        ack = 0;
        for (int i = 0; i < 4; i++) begin
            dec = i[0];
            fin = i[1];
            doRequest(dec, fin, rand128(), rand128(), hs);
            if (i > 0) begin
                checks++;
                if (hs != ack + 1) begin
                    failures++;
                    $display("[TB] FAIL b2b_accept: got handshake at %0d required %0d", hs, ack + 1);
                end
            end
            waitRsp(hs, 40, got, lat);
            exp = rspQ.pop_front();
            checks++;
            if (!got || rsp_state !== exp || lat != (fin ? 6 : 10)) begin
                failures++;
                $display("[TB] FAIL b2b_result%0d: got %h lat=%0d required %h lat=%0d", i, rsp_state, lat, exp, fin ? 6 : 10);
            end
            ackRsp(ack);
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        buildTables();
        test_reset();
        test_round("enc_final_zero", 0, 1, '0, '0, {16{8'h63}}, 1, 6);
        test_round("enc_nonfinal_zero", 0, 0, '0, '0, {16{8'h63}}, 1, 10);
        test_round("dec_final_ones", 1, 1, '0, {128{1'b1}}, {16{8'had}}, 1, 6);
        test_round("enc_nonfinal_rand", 0, 0, rand128(), rand128(), '0, 0, 10);
        test_stall();
        test_backpressure();
        test_watchdog();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (rspQ.size() != 0 || dpQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got rsp=%0d dp=%0d left required 0/0", rspQ.size(), dpQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
